fp_alu_arbiter: RTL and testbench
=================================

FP_ALU_ARBITER -- requirements
Module: fp_alu_arbiter

Interface
REQ-001 Parameter DEPTH, default 4: max operations in flight in the shared float_alu; power of two, at least 2.
REQ-002 Parameter W, default 32: operand/result width.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 reqN_valid  in  1  requester N (N=0,1) has an operation pending.
REQ-006 reqN_ready  out  1  requester N's operation is accepted this cycle.
REQ-007 reqN_op_a, reqN_op_b  in  W  operands.
REQ-008 reqN_op_code  in  3  opcode.
REQ-009 reqN_round_mode  in  1  rounding mode.
REQ-010 respN_valid  out  1  one-cycle pulse; result for requester N.
REQ-011 respN_result  out  W; respN_flags  out  5  result and flags.
REQ-012 alu_start  out  1  one-cycle issue pulse to float_alu.
REQ-013 alu_op_a, alu_op_b  out  W; alu_op_code  out  3; alu_round_mode  out  1; alu_mode_fp  out  1, tied 1.
REQ-014 alu_valid  in  1; alu_result  in  W; alu_flags  in  5  float_alu completion.
REQ-015 inflight  out  clog2(DEPTH)+1  registered count of outstanding operations.
REQ-016 err_spurious  out  1  sticky; alu_valid seen with nothing outstanding.

Function
REQ-017 The block SHALL treat float_alu as in-order: exactly one alu_valid per alu_start, in issue order.
REQ-018 Acceptance: reqN_ready = grant to N AND inflight < DEPTH; ready is combinational from registered state and reqN_valid, with no completion bypass.
REQ-019 Arbitration: round-robin; with both valid, grant goes to the requester opposite the last accepted one; with one valid, that one is granted.
REQ-020 At most one request SHALL be accepted per cycle.
REQ-021 Issue: an acceptance in cycle C SHALL register operands/opcode/round_mode onto alu_* and assert alu_start for exactly cycle C+1.
REQ-022 alu_* operand outputs SHALL hold their last value when alu_start is low.
REQ-023 On acceptance, the requester ID SHALL be pushed into an in-order tag FIFO of DEPTH entries.
REQ-024 On alu_valid with inflight > 0: pop the ID; in the next cycle, pulse respID_valid with alu_result/alu_flags registered.
REQ-025 respN_result/flags SHALL hold their last value when respN_valid is low; both resp valids never high together.
REQ-026 inflight: +1 on acceptance, -1 on a valid completion; simultaneous acceptance and completion leaves it unchanged (FIFO push and pop both occur).
REQ-027 Full (inflight == DEPTH): both readys low, even in a cycle with a completion.
REQ-028 alu_valid with inflight == 0: no pop, no response, err_spurious set until reset.
REQ-029 Tag FIFO pointers SHALL wrap modulo DEPTH.

Reset
REQ-030 The following SHALL be 0 during and after reset: alu_start, respN_valid, inflight, err_spurious, and all data outputs.
REQ-031 The round-robin state SHALL reset so requester 0 wins the first contention.
REQ-032 Reset mid-operation SHALL discard outstanding tags; later alu_valid pulses from those ops SHALL set err_spurious.

Structure
REQ-033 Shared package fp_alu_pkg: opcode constants, flag bit indices, DEPTH default.
REQ-034 One sub-module, fp_tag_fifo: 1-bit-wide, DEPTH-entry synchronous FIFO with push/pop/full/empty.

Verification
REQ-035 Both requesters valid from reset, alu_valid 3 cycles after each start -> grants alternate 0,1,0,1; responses return to 0,1,0,1 in order.
REQ-036 Req0 issues 4 ops, no completion (DEPTH=4) -> inflight=4, req0_ready and req1_ready low; one alu_valid -> ready returns the cycle after inflight drops to 3.
REQ-037 Completion and acceptance in the same cycle at inflight=2 -> inflight stays 2; the response goes to the correct popped ID.
REQ-038 alu_valid pulsed with inflight=0 -> no respN_valid; err_spurious=1 and stays 1.
REQ-039 rst_n asserted with 2 ops in flight, then 2 alu_valid -> no responses; err_spurious=1; inflight=0.
REQ-040 Request op_a=0x3F800000, op_b=0x40000000 accepted at cycle C -> alu_start high only at C+1 with those operands; alu_mode_fp=1.

Source files
------------

// File: rtl/fp_alu_pkg.sv
// Shared definitions for the float_alu arbiter slice: opcodes, flag bit
// positions, default sizing and the round-robin pointer type.
package fp_alu_pkg;

    localparam int unsigned DEPTH_DEFAULT = 4;
    localparam int unsigned W_DEFAULT     = 32;
    localparam int unsigned FLAGS_W       = 5;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_DIV  = 3'd3;
    localparam logic [2:0] OP_SQRT = 3'd4;
    localparam logic [2:0] OP_CMP  = 3'd5;
    localparam logic [2:0] OP_MIN  = 3'd6;
    localparam logic [2:0] OP_MAX  = 3'd7;

    localparam int unsigned FLAG_NX = 0;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_DZ = 3;
    localparam int unsigned FLAG_NV = 4;

    // Records which requester was accepted most recently.
    typedef enum logic {
        RR_LAST0 = 1'b0,
        RR_LAST1 = 1'b1
    } rr_state_t;

    function automatic logic rr_grant1(input logic v0, input logic v1,
                                       input rr_state_t last);
        return v1 && (!v0 || last == RR_LAST0);
    endfunction

endpackage

// File: rtl/fp_tag_fifo.sv
// In-order requester-ID FIFO: one bit per entry, DEPTH entries, pointers
// wrap naturally because DEPTH is a power of two.
module fp_tag_fifo
    import fp_alu_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic pop_id,
    output logic full,
    output logic empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_id  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fp_alu_arbiter.sv
// Two-requester round-robin front end for a shared, in-order float_alu.
// Responses are routed back by a tag FIFO of requester IDs.
module fp_alu_arbiter
    import fp_alu_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned W     = W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [W-1:0]             req0_op_a,
    input  logic [W-1:0]             req0_op_b,
    input  logic [2:0]               req0_op_code,
    input  logic                     req0_round_mode,

    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [W-1:0]             req1_op_a,
    input  logic [W-1:0]             req1_op_b,
    input  logic [2:0]               req1_op_code,
    input  logic                     req1_round_mode,

    output logic                     resp0_valid,
    output logic [W-1:0]             resp0_result,
    output logic [4:0]               resp0_flags,
    output logic                     resp1_valid,
    output logic [W-1:0]             resp1_result,
    output logic [4:0]               resp1_flags,

    output logic                     alu_start,
    output logic [W-1:0]             alu_op_a,
    output logic [W-1:0]             alu_op_b,
    output logic [2:0]               alu_op_code,
    output logic                     alu_round_mode,
    output logic                     alu_mode_fp,
    input  logic                     alu_valid,
    input  logic [W-1:0]             alu_result,
    input  logic [4:0]               alu_flags,

    output logic [$clog2(DEPTH):0]   inflight,
    output logic                     err_spurious
);

    rr_state_t rr_q;
    rr_state_t rr_d;
    logic      grant0;
    logic      grant1;
    logic      accept;
    logic      accept_id;
    logic      complete;
    logic      tag_full;
    logic      tag_empty;
    logic      pop_id;

    assign alu_mode_fp = 1'b1;

    // Tag FIFO occupancy equals inflight, so its full/empty drive acceptance
    // and completion qualification directly from registered state.
    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rr_d       = rr_q;
        grant1     = rr_grant1(req0_valid, req1_valid, rr_q);
        grant0     = req0_valid && !grant1;
        req0_ready = grant0 && !tag_full;
        req1_ready = grant1 && !tag_full;
        accept     = req0_ready || req1_ready;
        accept_id  = req1_ready;
        complete   = alu_valid && !tag_empty;
        if (accept) begin
            rr_d = accept_id ? RR_LAST1 : RR_LAST0;
        end
    end

    // Reset to "last was 1" so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= RR_LAST1;
        end else begin
            rr_q <= rr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_start      <= 1'b0;
            alu_op_a       <= '0;
            alu_op_b       <= '0;
            alu_op_code    <= '0;
            alu_round_mode <= 1'b0;
        end else begin
            alu_start <= accept;
            if (accept) begin
                alu_op_a       <= accept_id ? req1_op_a       : req0_op_a;
                alu_op_b       <= accept_id ? req1_op_b       : req0_op_b;
                alu_op_code    <= accept_id ? req1_op_code    : req0_op_code;
                alu_round_mode <= accept_id ? req1_round_mode : req0_round_mode;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp0_valid  <= 1'b0;
            resp0_result <= '0;
            resp0_flags  <= '0;
            resp1_valid  <= 1'b0;
            resp1_result <= '0;
            resp1_flags  <= '0;
        end else begin
            resp0_valid <= complete && !pop_id;
            resp1_valid <= complete && pop_id;
            if (complete && !pop_id) begin
                resp0_result <= alu_result;
                resp0_flags  <= alu_flags;
            end
            if (complete && pop_id) begin
                resp1_result <= alu_result;
                resp1_flags  <= alu_flags;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight     <= '0;
            err_spurious <= 1'b0;
        end else begin
            case ({accept, complete})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
            if (alu_valid && tag_empty) begin
                err_spurious <= 1'b1;
            end
        end
    end

    fp_tag_fifo #(
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (accept),
        .push_id (accept_id),
        .pop     (complete),
        .pop_id  (pop_id),
        .full    (tag_full),
        .empty   (tag_empty)
    );

endmodule

// File: tb/tb_fp_alu_arbiter.sv
// Self-checking bench: queue-based reference model plus an in-order float_alu
// emulator, directed scenarios with literal expectations, then random traffic.
module tb_fp_alu_arbiter;
    import fp_alu_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned W     = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [W-1:0]  req0_op_a = '0, req0_op_b = '0, req1_op_a = '0, req1_op_b = '0;
    logic [2:0]    req0_op_code = '0, req1_op_code = '0;
    logic          req0_round_mode = 1'b0, req1_round_mode = 1'b0;
    logic          resp0_valid, resp1_valid;
    logic [W-1:0]  resp0_result, resp1_result;
    logic [4:0]    resp0_flags, resp1_flags;
    logic          alu_start;
    logic [W-1:0]  alu_op_a, alu_op_b;
    logic [2:0]    alu_op_code;
    logic          alu_round_mode, alu_mode_fp;
    logic          alu_valid = 1'b0;
    logic [W-1:0]  alu_result = '0;
    logic [4:0]    alu_flags = '0;
    logic [2:0]    inflight;
    logic          err_spurious;

    fp_alu_arbiter #(.DEPTH(DEPTH), .W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op_a(req0_op_a), .req0_op_b(req0_op_b),
        .req0_op_code(req0_op_code), .req0_round_mode(req0_round_mode),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op_a(req1_op_a), .req1_op_b(req1_op_b),
        .req1_op_code(req1_op_code), .req1_round_mode(req1_round_mode),
        .resp0_valid(resp0_valid), .resp0_result(resp0_result), .resp0_flags(resp0_flags),
        .resp1_valid(resp1_valid), .resp1_result(resp1_result), .resp1_flags(resp1_flags),
        .alu_start(alu_start), .alu_op_a(alu_op_a), .alu_op_b(alu_op_b),
        .alu_op_code(alu_op_code), .alu_round_mode(alu_round_mode),
        .alu_mode_fp(alu_mode_fp), .alu_valid(alu_valid),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .inflight(inflight), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int           tagq[$];
    int           last_acc;
    logic         m_start, m_rm, m_rv0, m_rv1, m_err;
    logic [W-1:0] m_a, m_b, m_res0, m_res1;
    logic [2:0]   m_opc;
    logic [4:0]   m_flg0, m_flg1;

    // float_alu emulator
    int           due_q[$];
    logic [W-1:0] res_q[$];
    logic [4:0]   flg_q[$];
    int           alu_budget = -1;
    int           lat_min = 1, lat_max = 4;
    bit           spur_now = 0;
    int           cyc = 0;

    // Stimulus controls and per-cycle samples
    logic         s_v0 = 1'b0, s_v1 = 1'b0;
    bit           use_fixed = 0;
    logic [W-1:0] fix_a, fix_b;
    logic         smp_r0, smp_r1, smp_rv0, smp_rv1, smp_err, smp_start, smp_mode;
    logic [W-1:0] smp_a, smp_b;
    int           smp_inflight;
    int           resp_ids[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        tagq.delete();
        last_acc = 1;
        m_start = 0; m_rm = 0; m_rv0 = 0; m_rv1 = 0; m_err = 0;
        m_a = '0; m_b = '0; m_res0 = '0; m_res1 = '0; m_opc = '0;
        m_flg0 = '0; m_flg1 = '0;
    endtask

    task automatic check_regs();
        check("alu_start", alu_start, m_start);
        check("alu_op_a", alu_op_a, m_a);
        check("alu_op_b", alu_op_b, m_b);
        check("alu_op_code", alu_op_code, m_opc);
        check("alu_round_mode", alu_round_mode, m_rm);
        check("alu_mode_fp", alu_mode_fp, 1'b1);
        check("resp0_valid", resp0_valid, m_rv0);
        check("resp1_valid", resp1_valid, m_rv1);
        check("resp0_result", resp0_result, m_res0);
        check("resp0_flags", resp0_flags, m_flg0);
        check("resp1_result", resp1_result, m_res1);
        check("resp1_flags", resp1_flags, m_flg1);
        check("inflight", inflight, tagq.size());
        check("err_spurious", err_spurious, m_err);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; alu_valid = 1'b0;
        #2;
        model_reset();
        check_regs();
        @(posedge clk); #1;
        cyc++;
        check_regs();
        rst_n = 1'b1;
    endtask

    task automatic do_cycle();
        logic         a_v, full, g0, g1, r0, r1;
        logic [W-1:0] ar;
        logic [4:0]   af;
        int           d, id;
        check_regs();
        smp_inflight = int'(inflight);
        smp_rv0 = resp0_valid; smp_rv1 = resp1_valid; smp_err = err_spurious;
        smp_start = alu_start; smp_a = alu_op_a; smp_b = alu_op_b; smp_mode = alu_mode_fp;
        if (resp0_valid) resp_ids.push_back(0);
        if (resp1_valid) resp_ids.push_back(1);
        if (alu_start) begin
            d = cyc + int'($urandom_range(lat_max, lat_min));
            if (due_q.size() > 0 && d <= due_q[$]) d = due_q[$] + 1;
            due_q.push_back(d);
            res_q.push_back($urandom);
            flg_q.push_back(5'($urandom));
        end
        req0_valid = s_v0; req1_valid = s_v1;
        req0_op_a = use_fixed ? fix_a : $urandom;
        req0_op_b = use_fixed ? fix_b : $urandom;
        req1_op_a = $urandom; req1_op_b = $urandom;
        req0_op_code = 3'($urandom); req1_op_code = 3'($urandom);
        req0_round_mode = 1'($urandom); req1_round_mode = 1'($urandom);
        a_v = 1'b0; ar = $urandom; af = 5'($urandom);
        if (due_q.size() > 0 && due_q[0] <= cyc && alu_budget != 0) begin
            a_v = 1'b1;
            ar = res_q.pop_front();
            af = flg_q.pop_front();
            void'(due_q.pop_front());
            if (alu_budget > 0) alu_budget--;
        end else if (spur_now) begin
            a_v = 1'b1;
        end
        alu_valid = a_v; alu_result = ar; alu_flags = af;
        #1;
        full = (tagq.size() == int'(DEPTH));
        g0 = s_v0 && (!s_v1 || last_acc == 1);
        g1 = s_v1 && (!s_v0 || last_acc == 0);
        r0 = g0 && !full;
        r1 = g1 && !full;
        check("req0_ready", req0_ready, r0);
        check("req1_ready", req1_ready, r1);
        smp_r0 = req0_ready; smp_r1 = req1_ready;
        m_rv0 = 1'b0; m_rv1 = 1'b0;
        m_start = r0 || r1;
        if (a_v) begin
            if (tagq.size() > 0) begin
                id = tagq.pop_front();
                if (id == 0) begin m_rv0 = 1'b1; m_res0 = ar; m_flg0 = af; end
                else         begin m_rv1 = 1'b1; m_res1 = ar; m_flg1 = af; end
            end else begin
                m_err = 1'b1;
            end
        end
        if (r0) begin
            m_a = req0_op_a; m_b = req0_op_b; m_opc = req0_op_code; m_rm = req0_round_mode;
            tagq.push_back(0); last_acc = 0;
        end else if (r1) begin
            m_a = req1_op_a; m_b = req1_op_b; m_opc = req1_op_code; m_rm = req1_round_mode;
            tagq.push_back(1); last_acc = 1;
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        s_v0 = 1'b0; s_v1 = 1'b0;
        for (int i = 0; i < n; i++) do_cycle();
    endtask

    initial begin
        int exp_ids[4];
        exp_ids = '{0, 1, 0, 1};

        do_reset();

        // Alternating grants under contention, responses in issue order
        lat_min = 3; lat_max = 3; alu_budget = -1;
        resp_ids.delete();
        s_v0 = 1'b1; s_v1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_cycle();
            check("rr_grant0", smp_r0, (i % 2) == 0);
            check("rr_grant1", smp_r1, (i % 2) == 1);
        end
        idle(12);
        check("resp_count", resp_ids.size(), 4);
        for (int i = 0; i < 4 && i < resp_ids.size(); i++)
            check("resp_order", resp_ids[i], exp_ids[i]);

        // Full at DEPTH, ready returns the cycle after inflight drops
        do_reset();
        lat_min = 1; lat_max = 1; alu_budget = 0;
        s_v0 = 1'b1; s_v1 = 1'b0;
        for (int i = 0; i < 4; i++) do_cycle();
        s_v1 = 1'b1; alu_budget = 1;
        do_cycle();
        check("full_inflight", smp_inflight, 4);
        check("full_ready0", smp_r0, 1'b0);
        check("full_ready1", smp_r1, 1'b0);
        do_cycle();
        check("after_pop_inflight", smp_inflight, 3);
        check("after_pop_ready1", smp_r1, 1'b1);
        check("after_pop_ready0", smp_r0, 1'b0);
        alu_budget = -1;
        idle(12);

        // Completion and acceptance together at inflight=2
        do_reset();
        alu_budget = 0;
        s_v0 = 1'b1; s_v1 = 1'b1;
        do_cycle(); do_cycle();
        s_v1 = 1'b0; alu_budget = 1;
        do_cycle();
        check("swap_inflight_before", smp_inflight, 2);
        check("swap_ready0", smp_r0, 1'b1);
        alu_budget = 0; s_v0 = 1'b0;
        do_cycle();
        check("swap_inflight_after", smp_inflight, 2);
        check("swap_resp0", smp_rv0, 1'b1);
        check("swap_resp1", smp_rv1, 1'b0);
        alu_budget = -1;
        idle(12);

        // Spurious completion with nothing outstanding
        do_reset();
        idle(2);
        spur_now = 1;
        do_cycle();
        spur_now = 0;
        do_cycle();
        check("spur_err", smp_err, 1'b1);
        check("spur_resp0", smp_rv0, 1'b0);
        check("spur_resp1", smp_rv1, 1'b0);
        idle(5);
        check("spur_sticky", smp_err, 1'b1);

        // Reset with ops in flight: late completions are spurious
        do_reset();
        alu_budget = 0;
        s_v0 = 1'b1; s_v1 = 1'b1;
        do_cycle(); do_cycle();
        idle(1);
        do_reset();
        alu_budget = -1;
        resp_ids.delete();
        idle(6);
        check("rst_mid_resps", resp_ids.size(), 0);
        check("rst_mid_err", smp_err, 1'b1);
        check("rst_mid_inflight", smp_inflight, 0);

        // Issue timing and operand capture
        do_reset();
        use_fixed = 1; fix_a = 32'h3F80_0000; fix_b = 32'h4000_0000;
        s_v0 = 1'b1; s_v1 = 1'b0;
        do_cycle();
        check("issue_accept", smp_r0, 1'b1);
        check("issue_start_c", smp_start, 1'b0);
        use_fixed = 0; s_v0 = 1'b0;
        do_cycle();
        check("issue_start_c1", smp_start, 1'b1);
        check("issue_op_a", smp_a, 32'h3F80_0000);
        check("issue_op_b", smp_b, 32'h4000_0000);
        check("issue_mode_fp", smp_mode, 1'b1);
        do_cycle();
        check("issue_start_c2", smp_start, 1'b0);
        check("issue_op_a_hold", smp_a, 32'h3F80_0000);
        idle(8);

        // Random traffic
        lat_min = 1; lat_max = 5;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(999) < 3) do_reset();
            alu_budget = ((i % 200) < 25) ? 0 : -1;
            s_v0 = ($urandom_range(99) < 60);
            s_v1 = ($urandom_range(99) < 55);
            spur_now = (tagq.size() == 0) && (due_q.size() == 0) && ($urandom_range(99) < 5);
            do_cycle();
        end
        spur_now = 0;
        alu_budget = -1;
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
